iter_compare_unit: RTL and testbench
====================================

Name: iter_compare_unit

Overview:
- Multi-cycle, parametrised magnitude/equality comparator feeding branch resolution; successor to the single-cycle 32-bit comparator.
- Compares MSB-first, CHUNK bits per cycle, with signed/unsigned mode, optional early exit and valid/ready handshakes on both sides.
- Reports a flagged error on illegal op codes instead of holding a stale result.

Parameters:
- WIDTH, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK.
- EARLY_EXIT, 1, 1 = finish on the first differing chunk; 0 = always NCHUNK cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- oper  in  3  000 EQ, 001 NE, 010 LT, 011 LE, 100 GT, 101 GE; 110/111 illegal.
- is_signed  in  1  1 = two's-complement compare.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- result  out  1  outcome of A oper B.
- eq  out  1  A == B.
- lt  out  1  A < B, under the selected signedness.
- bad_op  out  1  oper was illegal; result forced to 0.

Behaviour:
- Reset values: in_ready=0 while rst_n low, then 1 in IDLE. out_valid, result, eq, lt, bad_op = 0. State = IDLE.
- States: IDLE, RUN, DONE. No other states.
- IDLE, on in_valid & in_ready:
  - Latch a, b, oper, is_signed.
  - Set idx = NCHUNK-1, eq_acc=1, lt_acc=0.
  - Go to RUN.
- RUN, each cycle, on chunk idx (idx = NCHUNK-1 is the MSB chunk):
  - Signed mode: the operand MSB is inverted in the top chunk before the unsigned chunk compare.
  - Chunks equal: decrement idx.
  - Chunks differ: eq_acc=0; lt_acc = (a_chunk < b_chunk); chunks below are ignored.
  - Exit to DONE when idx==0 has been compared, or on the first difference if EARLY_EXIT=1.
- DONE:
  - out_valid=1. result/eq/lt/bad_op are registered and held stable until out_valid & out_ready; then go to IDLE.
  - No bypass: in_ready is low in DONE, so a new request is taken no earlier than the cycle after handoff.
- Result mapping:
  - EQ = eq; NE = ~eq; LT = lt; LE = lt|eq; GT = ~lt & ~eq; GE = ~lt.
  - Illegal oper: bad_op=1, result=0; eq/lt still reported.
- Latency, counted from the accept edge to out_valid high:
  - EARLY_EXIT=0: NCHUNK cycles.
  - EARLY_EXIT=1: k cycles, where k = 1 + number of leading equal chunks (max NCHUNK).
- Boundaries:
  - CHUNK == WIDTH: single RUN cycle.
  - in_valid in RUN/DONE is ignored and not queued; the source must hold it.
  - Inputs changing after accept have no effect.
  - rst_n asserted mid-RUN/DONE: immediate abort, all outputs to reset values, result discarded.
  - out_ready high while out_valid is low: no effect.
- Elaboration: an assertion fails if WIDTH % CHUNK != 0 or if CHUNK < 1.

Decomposition:
- Package cmp_pkg:
  - oper encodings: OP_EQ..OP_GE, plus OP_ILLEGAL range check.
  - State enum: IDLE/RUN/DONE.
  - Function mapping (oper, eq, lt) to result.
- Sub-module chunk_cmp: combinational CHUNK-bit unsigned compare, outputs c_eq and c_lt; instantiated once and muxed by idx.

Test Plan:
- WIDTH=32, CHUNK=8, EARLY_EXIT=1; a=5, b=5, oper=EQ, unsigned -> out_valid 4 cycles after accept, result=1, eq=1, lt=0.
- a=0x80000000, b=0x00000001, oper=LT, signed -> result=1, latency 1. Same operands unsigned -> result=0, lt=0.
- a=0x12345678, b=0x12345679, oper=GT, EARLY_EXIT=0 -> result=0, lt=1, latency 4. With EARLY_EXIT=1 -> latency 4.
- oper=3'b110, a=b=0 -> bad_op=1, result=0, eq=1.
- Hold out_ready low 3 cycles in DONE -> outputs stable, in_ready=0, extra in_valid ignored; on the handshake -> IDLE next cycle, in_ready=1.
- Drop rst_n during RUN -> out_valid=0 and in_ready=0 immediately; after release, a new EQ request completes correctly.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative comparator: operation codes,
// controller states and the (oper, eq, lt) -> result mapping.
package cmp_pkg;

  // Operation encodings presented on the oper input
  localparam logic [2:0] OP_EQ = 3'b000;
  localparam logic [2:0] OP_NE = 3'b001;
  localparam logic [2:0] OP_LT = 3'b010;
  localparam logic [2:0] OP_LE = 3'b011;
  localparam logic [2:0] OP_GT = 3'b100;
  localparam logic [2:0] OP_GE = 3'b101;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Codes above OP_GE (110, 111) have no defined meaning
  function automatic logic op_illegal(input logic [2:0] op);
    return (op > OP_GE);
  endfunction

  // Collapse the equality/less-than pair into the requested outcome;
  // illegal codes yield 0
  function automatic logic map_result(input logic [2:0] op,
                                      input logic       is_eq,
                                      input logic       is_lt);
    logic r;
    case (op)
      OP_EQ:   r = is_eq;
      OP_NE:   r = ~is_eq;
      OP_LT:   r = is_lt;
      OP_LE:   r = is_lt | is_eq;
      OP_GT:   r = ~is_lt & ~is_eq;
      OP_GE:   r = ~is_lt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module chunk_cmp
  import cmp_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             c_eq,
  output logic             c_lt
);

  assign c_eq = (a == b);
  assign c_lt = (a < b);

endmodule

// File: rtl/iter_compare_unit.sv
// Multi-cycle magnitude/equality comparator. Walks the operands MSB chunk
// first, CHUNK bits per cycle, with optional exit on the first differing
// chunk. Signed compares are handled by flipping the operand sign bits on
// capture, which turns a two's-complement order into an unsigned one.
module iter_compare_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       oper,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             eq,
  output logic             lt,
  output logic             bad_op
);

  localparam int SAFE_CHUNK = (CHUNK > 0) ? CHUNK : 1;
  localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
  localparam int IDX_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  // Reject configurations where the operand does not split into whole chunks
  if ((CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_bad_cfg
    $error("iter_compare_unit: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       oper_q;
  logic [IDX_W-1:0] idx;
  logic             eq_acc;
  logic             lt_acc;

  logic [WIDTH-1:0] sign_mask;
  logic             accept;

  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic [CHUNK-1:0] sel_a;
  logic [CHUNK-1:0] sel_b;
  logic             c_eq;
  logic             c_lt;

  logic             eq_next;
  logic             lt_next;
  logic             last;

  assign accept = (state == IDLE) && in_valid && in_ready;

  // Sign-bit flip applied on capture when a two's-complement compare is asked
  always_comb begin
    sign_mask            = '0;
    sign_mask[WIDTH-1]   = is_signed;
  end

  // Capture operands and op on acceptance; later input changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= a ^ sign_mask;
      b_q    <= b ^ sign_mask;
      oper_q <= oper;
    end
  end

  // Slice the captured operands into chunk arrays for the idx mux
  for (genvar g = 0; g < NCHUNK; g++) begin : g_slice
    assign a_chunk[g] = a_q[g*CHUNK +: CHUNK];
    assign b_chunk[g] = b_q[g*CHUNK +: CHUNK];
  end

  assign sel_a = a_chunk[idx];
  assign sel_b = b_chunk[idx];

  chunk_cmp #(
    .CHUNK (CHUNK)
  ) u_chunk_cmp (
    .a    (sel_a),
    .b    (sel_b),
    .c_eq (c_eq),
    .c_lt (c_lt)
  );

  // Fold the current chunk into the accumulators; once a difference has been
  // seen, lower chunks no longer influence the outcome
  always_comb begin
    eq_next = eq_acc & c_eq;
    lt_next = eq_acc ? c_lt : lt_acc;
    last    = (idx == '0) || (EARLY_EXIT && eq_acc && !c_eq);
  end

  // Controller: accept in IDLE, iterate chunks in RUN, hold result in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      bad_op    <= 1'b0;
      idx       <= '0;
      eq_acc    <= 1'b1;
      lt_acc    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= RUN;
            in_ready <= 1'b0;
            idx      <= IDX_TOP;
            eq_acc   <= 1'b1;
            lt_acc   <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          eq_acc <= eq_next;
          lt_acc <= lt_next;
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            eq        <= eq_next;
            lt        <= lt_next;
            bad_op    <= op_illegal(oper_q);
            result    <= op_illegal(oper_q) ? 1'b0
                                            : map_result(oper_q, eq_next, lt_next);
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_compare_unit.sv
// Directed bench for iter_compare_unit: one early-exit and one full-length
// instance, expected outcomes queued on request and checked on out_valid.
module tb_iter_compare_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready = '0;
  logic [1:0]  result;
  logic [1:0]  eq;
  logic [1:0]  lt;
  logic [1:0]  bad_op;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  oper = '0;
  logic        is_signed = 1'b0;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  typedef struct {
    logic res;
    logic eq;
    logic lt;
    logic bad;
    int   lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  iter_compare_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .oper(oper), .is_signed(is_signed),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]),
    .eq(eq[0]), .lt(lt[0]), .bad_op(bad_op[0])
  );

  iter_compare_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .oper(oper), .is_signed(is_signed),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]),
    .eq(eq[1]), .lt(lt[1]), .bad_op(bad_op[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int u, input logic [31:0] ta, input logic [31:0] tb,
                                 input logic [2:0] top, input logic ts);
    exp_t e;
    logic same;
    e.eq  = (ta == tb);
    e.lt  = ts ? ($signed(ta) < $signed(tb)) : (ta < tb);
    e.bad = (top > 3'd5);
    case (top)
      3'd0:    e.res = e.eq;
      3'd1:    e.res = !e.eq;
      3'd2:    e.res = e.lt;
      3'd3:    e.res = e.lt || e.eq;
      3'd4:    e.res = !e.lt && !e.eq;
      3'd5:    e.res = !e.lt;
      default: e.res = 1'b0;
    endcase
    if (u == 1) begin
      e.lat = 4;
    end else begin
      e.lat = 1;
      same  = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        if (same && (ta[i*8 +: 8] == tb[i*8 +: 8])) e.lat++;
        else same = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic start(input int u, input logic [31:0] ta, input logic [31:0] tb,
                       input logic [2:0] top, input logic ts);
    int n;
    n = 0;
    while (in_ready[u] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_req", in_ready[u], 1);
    sb.push_back(model(u, ta, tb, top, ts));
    a = ta; b = tb; oper = top; is_signed = ts;
    in_valid[u] = 1'b1;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    // Scramble inputs after the accept edge; the captured request must win
    a = ~ta; b = ~tb; oper = 3'b000; is_signed = ~ts;
  endtask

  task automatic finish(input int u, input int hold, input bit early_ready);
    int   lat;
    exp_t e;
    if (early_ready) out_ready[u] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (out_valid[u] !== 1'b1 && lat < 20);
    check("out_valid_seen", out_valid[u], 1);
    if (out_valid[u] === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check("latency", lat, e.lat);
      check("result", result[u], e.res);
      check("eq", eq[u], e.eq);
      check("lt", lt[u], e.lt);
      check("bad_op", bad_op[u], e.bad);
      check("in_ready_done", in_ready[u], 0);
      for (int i = 0; i < hold; i++) begin
        in_valid[u] = 1'b1;
        a = 32'hDEAD_0000 + i; b = 32'h0000_BEEF; oper = 3'b001;
        @(posedge clk); #1;
        check("hold_out_valid", out_valid[u], 1);
        check("hold_result", result[u], e.res);
        check("hold_eq", eq[u], e.eq);
        check("hold_lt", lt[u], e.lt);
        check("hold_in_ready", in_ready[u], 0);
      end
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b1;
      if (!early_ready) begin
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
      end
      out_ready[u] = 1'b0;
      check("handoff_out_valid", out_valid[u], 0);
      check("handoff_in_ready", in_ready[u], 1);
      if (hold > 0) begin
        @(posedge clk); #1;
        check("no_queued_out_valid", out_valid[u], 0);
        check("no_queued_in_ready", in_ready[u], 1);
      end
    end
    out_ready[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_in_ready", in_ready[u], 0);
      check("rst_out_valid", out_valid[u], 0);
      check("rst_result", result[u], 0);
      check("rst_eq", eq[u], 0);
      check("rst_lt", lt[u], 0);
      check("rst_bad_op", bad_op[u], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready_ee", in_ready[0], 1);
    check("idle_in_ready_full", in_ready[1], 1);

    // Equal operands walk every chunk
    start(0, 32'd5, 32'd5, 3'b000, 1'b0);                  finish(0, 0, 0);
    // Sign decides in the top chunk
    start(0, 32'h8000_0000, 32'h0000_0001, 3'b010, 1'b1);  finish(0, 0, 0);
    start(0, 32'h8000_0000, 32'h0000_0001, 3'b010, 1'b0);  finish(0, 0, 0);
    // Difference only in the bottom chunk, both exit modes
    start(0, 32'h1234_5678, 32'h1234_5679, 3'b100, 1'b0);  finish(0, 0, 0);
    start(1, 32'h1234_5678, 32'h1234_5679, 3'b100, 1'b0);  finish(1, 0, 0);
    // Illegal code on equal operands
    start(0, 32'h0, 32'h0, 3'b110, 1'b0);                  finish(0, 0, 0);
    // Negative vs negative, consumer ready before out_valid
    start(1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b101, 1'b1);  finish(1, 0, 1);
    // Difference in second chunk
    start(0, 32'h0001_0000, 32'h0002_0000, 3'b001, 1'b0);  finish(0, 0, 0);
    // Positive vs negative, signed GT
    start(0, 32'h7F00_0000, 32'h8000_0000, 3'b100, 1'b1);  finish(0, 0, 0);
    // LE on equal operands without early exit
    start(1, 32'h0000_FF00, 32'h0000_FF00, 3'b011, 1'b0);  finish(1, 0, 0);
    // Illegal code still reports lt
    start(0, 32'hC000_0000, 32'h4000_0000, 3'b111, 1'b1);  finish(0, 0, 0);
    // Consumer stalls three cycles with a competing request present
    start(0, 32'h0102_0304, 32'h0102_0304, 3'b010, 1'b0);  finish(0, 3, 0);

    // Reset during RUN aborts the request
    start(0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b000, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid[0], 0);
    check("abort_in_ready", in_ready[0], 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start(0, 32'h00C0_FFEE, 32'h00C0_FFEE, 3'b000, 1'b0);  finish(0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
